btn_direction_ctrl: RTL and testbench

Upstream control stage for the LED up/down counter. It takes a raw pushbutton and produces the counter's `direction` level. The button is synchronised and debounced. Each accepted press toggles `direction`, and one-cycle event pulses are exported for other board logic. It sits between the board pin and the counter's `direction` input.

---
 rtl/btn_direction_ctrl.sv | 169 ++++++++++++++++
 tb/tb_btn_direction_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_direction_ctrl.sv
// btn_direction_ctrl: synchronises and debounces a raw pushbutton and toggles
// the up/down counter direction on each accepted press.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   reset        synchronous active-high reset
//   btn_in       raw asynchronous button pin
//   direction    count direction to the counter (1 = up, 0 = down)
//   btn_level    debounced button state (1 = pressed)
//   press_pulse  one-cycle strobe on each accepted press
//   long_pulse   one-cycle strobe on long-press detection (0 when disabled)
//
// Optional feature macro: BTN_LONG_PRESS_EN
//   undefined: direction toggles when press_pulse fires, long_pulse tied 0
//   defined:   toggle deferred to release acceptance and skipped after a long
//              press; a long press raises long_pulse and forces direction up

module btn_direction_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter bit DIR_RESET       = 1'b1,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic direction,
    output logic btn_level,
    output logic press_pulse,
    output logic long_pulse
);

    localparam int CW = $clog2(LONG_CYCLES + 1);

    // Debounce completes on the edge where the count would reach the limit.
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES);
`ifdef BTN_LONG_PRESS_EN
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`endif

    // Pin level that corresponds to a released button.
    localparam logic REL_LVL = BTN_ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          dir_q, dir_d;
    logic          lvl_q, lvl_d;
    logic          press_q, press_d;
    logic          long_q, long_d;
    logic          pressed;

    assign pressed = BTN_ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= {2{REL_LVL}};
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            dir_q   <= DIR_RESET;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_in};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            dir_q   <= dir_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            long_q  <= long_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        dir_d   = dir_q;
        lvl_d   = lvl_q;
        press_d = 1'b0;
        long_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end

            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    hold_d  = '0;
                    lvl_d   = 1'b1;
                    press_d = 1'b1;
`ifndef BTN_LONG_PRESS_EN
                    dir_d   = ~dir_q;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            HELD: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CW'(1);
                end else if (hold_q != LONG_MAX) begin
                    // Saturates at LONG_MAX so a long hold fires only once.
                    hold_d = hold_q + CW'(1);
`ifdef BTN_LONG_PRESS_EN
                    if (hold_q == LONG_LAST) begin
                        long_d = 1'b1;
                        dir_d  = 1'b1;
                    end
`endif
                end
            end

            RELEASE_WAIT: begin
                // hold_q is untouched here, so a bounce back into HELD
                // resumes the hold count where it left off.
                if (pressed) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    lvl_d   = 1'b0;
`ifdef BTN_LONG_PRESS_EN
                    if (hold_q != LONG_MAX) begin
                        dir_d = ~dir_q;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign direction   = dir_q;
    assign btn_level   = lvl_q;
    assign press_pulse = press_q;
    assign long_pulse  = long_q;

endmodule

// File: tb/tb_btn_direction_ctrl.sv
// tb_btn_direction_ctrl: directed self-checking bench for btn_direction_ctrl
// with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, active-low pin.

module tb_btn_direction_ctrl;

    logic clk;
    logic reset;
    logic btn_in;
    logic direction;
    logic btn_level;
    logic press_pulse;
    logic long_pulse;

    int tests;
    int fails;

    int cyc;
    int press_cnt;
    int press_cyc;
    int long_cnt;
    int long_cyc;
    int fall_cyc;
    int rise_cnt;
    int dir_chg_cnt;
    int dir_chg_cyc;
    logic dir_at_press;
    logic dir_prev;
    logic lvl_prev;

    btn_direction_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .DIR_RESET      (1'b1),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .direction  (direction),
        .btn_level  (btn_level),
        .press_pulse(press_pulse),
        .long_pulse (long_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and record output events just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (press_pulse === 1'b1) begin
            press_cnt++;
            press_cyc    = cyc;
            dir_at_press = direction;
        end
        if (long_pulse === 1'b1) begin
            long_cnt++;
            long_cyc = cyc;
        end
        if (lvl_prev === 1'b1 && btn_level === 1'b0) fall_cyc = cyc;
        if (lvl_prev === 1'b0 && btn_level === 1'b1) rise_cnt++;
        if (direction !== dir_prev) begin
            dir_chg_cnt++;
            dir_chg_cyc = cyc;
        end
        dir_prev = direction;
        lvl_prev = btn_level;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_stats();
        press_cnt    = 0;
        press_cyc    = -1;
        long_cnt     = 0;
        long_cyc     = -1;
        fall_cyc     = -1;
        rise_cnt     = 0;
        dir_chg_cnt  = 0;
        dir_chg_cyc  = -1;
        dir_at_press = 1'bx;
        dir_prev     = direction;
        lvl_prev     = btn_level;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        btn_in = 1'b1;
        ticks(3);
        reset = 1'b0;
        clear_stats();
    endtask

    task automatic test_reset();
        int c0;
        reset  = 1'b1;
        btn_in = 1'b0;
        ticks(3);
        tests++;
        if (direction !== 1'b1) begin
            fails++;
            $display("FAIL reset_dir got %b want 1", direction);
        end
        tests++;
        if (btn_level !== 1'b0 || press_pulse !== 1'b0 || long_pulse !== 1'b0) begin
            fails++;
            $display("FAIL reset_outs got lvl=%b press=%b long=%b want 0 0 0",
                     btn_level, press_pulse, long_pulse);
        end
        reset = 1'b0;
        clear_stats();
        c0 = cyc;
        ticks(5);
        tests++;
        if (press_cnt !== 0) begin
            fails++;
            $display("FAIL reset_early_press got %0d want 0", press_cnt);
        end
        tick();
        tests++;
        if (press_pulse !== 1'b1 || press_cyc !== c0 + 6) begin
            fails++;
            $display("FAIL reset_press_latency got pulse=%b at %0d want 1 at %0d",
                     press_pulse, press_cyc - c0, 6);
        end
        tick();
        tests++;
        if (press_pulse !== 1'b0) begin
            fails++;
            $display("FAIL reset_press_width got %b want 0", press_pulse);
        end
        btn_in = 1'b1;
        ticks(10);
    endtask

    task automatic test_press();
        int c0;
        int c1;
        do_reset();
        btn_in = 1'b0;
        c0 = cyc;
        ticks(10);
        btn_in = 1'b1;
        c1 = cyc;
        ticks(12);
        tests++;
        if (press_cnt !== 1 || press_cyc !== c0 + 6) begin
            fails++;
            $display("FAIL press_pulse got cnt=%0d at %0d want 1 at 6",
                     press_cnt, press_cyc - c0);
        end
        tests++;
        if (fall_cyc !== c1 + 6) begin
            fails++;
            $display("FAIL press_release_lat got %0d want 6", fall_cyc - c1);
        end
        tests++;
        if (direction !== 1'b0 || dir_chg_cnt !== 1 || long_cnt !== 0) begin
            fails++;
            $display("FAIL press_dir got dir=%b chg=%0d long=%0d want 0 1 0",
                     direction, dir_chg_cnt, long_cnt);
        end
`ifdef BTN_LONG_PRESS_EN
        tests++;
        if (dir_at_press !== 1'b1 || dir_chg_cyc !== fall_cyc) begin
            fails++;
            $display("FAIL press_toggle_edge got dir=%b at %0d want 1, toggle at %0d",
                     dir_at_press, dir_chg_cyc, fall_cyc);
        end
`else
        tests++;
        if (dir_at_press !== 1'b0 || dir_chg_cyc !== press_cyc) begin
            fails++;
            $display("FAIL press_toggle_edge got dir=%b at %0d want 0, toggle at %0d",
                     dir_at_press, dir_chg_cyc, press_cyc);
        end
`endif
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 30; i++) begin
            btn_in = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
        end
        btn_in = 1'b1;
        ticks(10);
        tests++;
        if (press_cnt !== 0 || rise_cnt !== 0) begin
            fails++;
            $display("FAIL bounce_outs got press=%0d rise=%0d want 0 0",
                     press_cnt, rise_cnt);
        end
        tests++;
        if (direction !== 1'b1 || btn_level !== 1'b0) begin
            fails++;
            $display("FAIL bounce_state got dir=%b lvl=%b want 1 0",
                     direction, btn_level);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        btn_in = 1'b0;
        ticks(8);
        btn_in = 1'b1;
        ticks(10);
        tests++;
        if (press_cnt !== 1 || direction !== 1'b0) begin
            fails++;
            $display("FAIL b2b_first got press=%0d dir=%b want 1 0",
                     press_cnt, direction);
        end
        btn_in = 1'b0;
        ticks(8);
        btn_in = 1'b1;
        ticks(12);
        tests++;
        if (press_cnt !== 2 || direction !== 1'b1 || dir_chg_cnt !== 2) begin
            fails++;
            $display("FAIL b2b_second got press=%0d dir=%b chg=%0d want 2 1 2",
                     press_cnt, direction, dir_chg_cnt);
        end
        do_reset();
        btn_in = 1'b0;
        ticks(8);
        btn_in = 1'b1;
        ticks(2);
        btn_in = 1'b0;
        ticks(8);
        btn_in = 1'b1;
        ticks(12);
        tests++;
        if (press_cnt !== 1 || direction !== 1'b0 || dir_chg_cnt !== 1) begin
            fails++;
            $display("FAIL gap_single got press=%0d dir=%b chg=%0d want 1 0 1",
                     press_cnt, direction, dir_chg_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int cr;
        do_reset();
        btn_in = 1'b0;
        ticks(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cr = cyc;
        ticks(5);
        tests++;
        if (press_cnt !== 0 || direction !== 1'b1 || btn_level !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_discard got press=%0d dir=%b lvl=%b want 0 1 0",
                     press_cnt, direction, btn_level);
        end
        tick();
        tests++;
        if (press_cnt !== 1 || press_cyc !== cr + 6) begin
            fails++;
            $display("FAIL mid_reset_redebounce got cnt=%0d at %0d want 1 at 6",
                     press_cnt, press_cyc - cr);
        end
        btn_in = 1'b1;
        ticks(12);
    endtask

    task automatic test_long();
        do_reset();
        btn_in = 1'b0;
        ticks(40);
        btn_in = 1'b1;
        ticks(12);
        tests++;
        if (press_cnt !== 1) begin
            fails++;
            $display("FAIL long_press_cnt got %0d want 1", press_cnt);
        end
`ifdef BTN_LONG_PRESS_EN
        tests++;
        if (long_cnt !== 1 || long_cyc !== press_cyc + 20) begin
            fails++;
            $display("FAIL long_pulse got cnt=%0d at +%0d want 1 at +20",
                     long_cnt, long_cyc - press_cyc);
        end
        tests++;
        if (direction !== 1'b1 || dir_chg_cnt !== 0) begin
            fails++;
            $display("FAIL long_no_toggle got dir=%b chg=%0d want 1 0",
                     direction, dir_chg_cnt);
        end
`else
        tests++;
        if (long_cnt !== 0) begin
            fails++;
            $display("FAIL long_pulse got cnt=%0d want 0", long_cnt);
        end
        tests++;
        if (direction !== 1'b0 || dir_chg_cnt !== 1) begin
            fails++;
            $display("FAIL long_dir got dir=%b chg=%0d want 0 1",
                     direction, dir_chg_cnt);
        end
`endif
        do_reset();
        btn_in = 1'b0;
        ticks(8);
        btn_in = 1'b1;
        ticks(12);
        tests++;
        if (direction !== 1'b0 || long_cnt !== 0) begin
            fails++;
            $display("FAIL short_dir got dir=%b long=%0d want 0 0",
                     direction, long_cnt);
        end
`ifdef BTN_LONG_PRESS_EN
        tests++;
        if (dir_chg_cyc !== fall_cyc) begin
            fails++;
            $display("FAIL short_toggle_edge got %0d want %0d",
                     dir_chg_cyc, fall_cyc);
        end
`else
        tests++;
        if (dir_chg_cyc !== press_cyc) begin
            fails++;
            $display("FAIL short_toggle_edge got %0d want %0d",
                     dir_chg_cyc, press_cyc);
        end
`endif
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        cyc    = 0;
        reset  = 1'b1;
        btn_in = 1'b1;
        dir_prev = 1'b1;
        lvl_prev = 1'b0;
        clear_stats();
        test_reset();
        test_press();
        test_bounce();
        test_back_to_back();
        test_reset_mid();
        test_long();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
